// File: rtl/sm_uart_rx_frame_ctrl_pkg.sv
// Shared types and constants for the UART frame controller.
package sm_uart_frame_pkg;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHECK   = 3'd3,
    END     = 3'd4,
    HOLD    = 3'd5
  } state_t;

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_BAD_LEN  = 3'd1;
  localparam logic [2:0] ERR_CHECKSUM = 3'd2;
  localparam logic [2:0] ERR_NO_EOF   = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT  = 3'd4;
  localparam logic [2:0] ERR_OVERRUN  = 3'd5;

  localparam logic [7:0] DEF_SOF_BYTE = 8'h23;
  localparam logic [7:0] DEF_EOF_BYTE = 8'h0A;

  // Increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sm_uart_rx_frame_ctrl_if.sv
// Byte-stream input, frame handoff and status signals of the frame controller.
// Signal names are written from the controller's point of view.
interface sm_uart_rx_frame_ctrl_if #(
  parameter int unsigned MAX_LEN = 16
);
  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [7:0]        i_rx_byte;
  logic              i_rx_valid;
  logic              o_frame_valid;
  logic              i_frame_ack;
  logic [7:0]        o_frame_len;
  logic [ADDR_W-1:0] i_rd_addr;
  logic [7:0]        o_rd_data;
  logic              o_err_strobe;
  logic [2:0]        o_err_code;
  logic              o_busy;
  logic [7:0]        o_drop_count;

  // Driver of bytes / consumer of frames.
  modport master (
    output i_rx_byte, i_rx_valid, i_frame_ack, i_rd_addr,
    input  o_frame_valid, o_frame_len, o_rd_data, o_err_strobe,
           o_err_code, o_busy, o_drop_count
  );

  // The frame controller itself.
  modport slave (
    input  i_rx_byte, i_rx_valid, i_frame_ack, i_rd_addr,
    output o_frame_valid, o_frame_len, o_rd_data, o_err_strobe,
           o_err_code, o_busy, o_drop_count
  );
endinterface

// File: rtl/sm_uart_rx_frame_ctrl_timeout.sv
// Inter-byte idle counter: 16-bit, clear has priority over enable,
// terminal count flags when the count equals TIMEOUT_CLKS.
module sm_frame_timeout #(
  parameter int unsigned TIMEOUT_CLKS = 43400
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  logic [15:0] r_cnt;

  // Count idle cycles; stop at all-ones so the counter cannot wrap back under the limit.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt <= 16'd0;
    end else if (i_clr) begin
      r_cnt <= 16'd0;
    end else if (i_en && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_tc = (r_cnt == 16'(TIMEOUT_CLKS));
endmodule

// File: rtl/sm_uart_rx_frame_ctrl.sv
// Frame-level controller behind the UART byte receiver:
// SOF, length, payload, XOR checksum, EOF; buffers one verified frame
// for the consumer and reports malformed frames, timeouts and overruns.
module sm_uart_rx_frame_ctrl
  import sm_uart_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN      = 16,
  parameter logic [7:0]  SOF_BYTE     = DEF_SOF_BYTE,
  parameter logic [7:0]  EOF_BYTE     = DEF_EOF_BYTE,
  parameter int unsigned TIMEOUT_CLKS = 43400
) (
  input  logic                  CLOCK,
  input  logic                  RESET_N,
  sm_uart_rx_frame_ctrl_if.slave bus
);
  localparam int ADDR_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  state_t            r_state;
  logic [7:0]        r_len;
  logic [7:0]        r_chk;
  logic [ADDR_W-1:0] r_idx;
  logic              r_frame_valid;
  logic              r_busy;
  logic              r_err_strobe;
  logic [2:0]        r_err_code;
  logic [7:0]        r_drop_count;
  logic [7:0]        r_buf [MAX_LEN];

  logic w_in_frame;
  logic w_to_clr;
  logic w_to_tc;
  logic w_len_ok;
  logic w_idx_last;
  logic w_is_sof;
  logic w_wr_en;

  assign w_in_frame = (r_state == LEN) || (r_state == PAYLOAD) ||
                      (r_state == CHECK) || (r_state == END);
  assign w_to_clr   = bus.i_rx_valid || !w_in_frame;
  assign w_len_ok   = (bus.i_rx_byte != 8'd0) && (32'(bus.i_rx_byte) <= MAX_LEN);
  assign w_idx_last = (8'(r_idx) == (r_len - 8'd1));
  assign w_is_sof   = (bus.i_rx_byte == SOF_BYTE);
  assign w_wr_en    = bus.i_rx_valid && (r_state == PAYLOAD);

  sm_frame_timeout #(
    .TIMEOUT_CLKS (TIMEOUT_CLKS)
  ) u_timeout (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .i_clr   (w_to_clr),
    .i_en    (w_in_frame),
    .o_tc    (w_to_tc)
  );

  // Framing state machine with registered status outputs.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state       <= HUNT;
      r_len         <= 8'd0;
      r_chk         <= 8'd0;
      r_idx         <= '0;
      r_frame_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_err_strobe  <= 1'b0;
      r_err_code    <= ERR_NONE;
      r_drop_count  <= 8'd0;
    end else begin
      r_err_strobe <= 1'b0;
      if ((r_state == HOLD) && bus.i_frame_ack) begin
        // Ack releases the buffer; a coincident byte is treated as if in HUNT.
        r_frame_valid <= 1'b0;
        if (bus.i_rx_valid && w_is_sof) begin
          r_state <= LEN;
          r_busy  <= 1'b1;
        end else begin
          r_state <= HUNT;
          r_busy  <= 1'b0;
        end
      end else if (bus.i_rx_valid) begin
        unique case (r_state)
          HUNT: begin
            if (w_is_sof) begin
              r_state <= LEN;
              r_busy  <= 1'b1;
            end
          end
          LEN: begin
            if (w_len_ok) begin
              r_len   <= bus.i_rx_byte;
              r_chk   <= bus.i_rx_byte;
              r_idx   <= '0;
              r_state <= PAYLOAD;
            end else begin
              r_err_strobe <= 1'b1;
              r_err_code   <= ERR_BAD_LEN;
              r_state      <= HUNT;
              r_busy       <= 1'b0;
            end
          end
          PAYLOAD: begin
            r_chk <= r_chk ^ bus.i_rx_byte;
            r_idx <= r_idx + ADDR_W'(1);
            if (w_idx_last) begin
              r_state <= CHECK;
            end
          end
          CHECK: begin
            if (bus.i_rx_byte == r_chk) begin
              r_state <= END;
            end else begin
              r_err_strobe <= 1'b1;
              r_err_code   <= ERR_CHECKSUM;
              r_state      <= HUNT;
              r_busy       <= 1'b0;
            end
          end
          END: begin
            if (bus.i_rx_byte == EOF_BYTE) begin
              r_state       <= HOLD;
              r_frame_valid <= 1'b1;
            end else begin
              r_err_strobe <= 1'b1;
              r_err_code   <= ERR_NO_EOF;
              r_state      <= HUNT;
              r_busy       <= 1'b0;
            end
          end
          HOLD: begin
            // Buffer is owned by the consumer: drop the byte and flag it.
            r_drop_count <= sat_inc8(r_drop_count);
            r_err_strobe <= 1'b1;
            r_err_code   <= ERR_OVERRUN;
          end
          default: begin
            r_state <= HUNT;
            r_busy  <= 1'b0;
          end
        endcase
      end else if (w_in_frame && w_to_tc) begin
        r_err_strobe <= 1'b1;
        r_err_code   <= ERR_TIMEOUT;
        r_state      <= HUNT;
        r_busy       <= 1'b0;
      end
    end
  end

  // Payload store; only written while collecting payload, never in HOLD.
  always_ff @(posedge CLOCK) begin
    if (w_wr_en) begin
      r_buf[r_idx] <= bus.i_rx_byte;
    end
  end

  assign bus.o_frame_valid = r_frame_valid;
  assign bus.o_frame_len   = r_frame_valid ? r_len : 8'd0;
  assign bus.o_rd_data     = (r_frame_valid && (32'(bus.i_rd_addr) < MAX_LEN)) ?
                             r_buf[bus.i_rd_addr] : 8'd0;
  assign bus.o_err_strobe  = r_err_strobe;
  assign bus.o_err_code    = r_err_code;
  assign bus.o_busy        = r_busy;
  assign bus.o_drop_count  = r_drop_count;
endmodule

// File: tb/tb_sm_uart_rx_frame_ctrl.sv
// Scoreboard bench for the UART frame controller.
module tb_sm_uart_rx_frame_ctrl;
  import sm_uart_frame_pkg::*;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned TO_CLKS = 500;

  typedef struct packed {
    logic [7:0]                len;
    logic [MAX_LEN-1:0][7:0]   data;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sm_uart_rx_frame_ctrl_if #(.MAX_LEN(MAX_LEN)) bus ();

  sm_uart_rx_frame_ctrl #(
    .MAX_LEN      (MAX_LEN),
    .TIMEOUT_CLKS (TO_CLKS)
  ) u_dut (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [2:0] exp_err_q [$];
  frame_t     exp_frame_q [$];
  int frames_pushed = 0;
  int frames_seen = 0;
  logic fv_d = 1'b0;
  logic [MAX_LEN-1:0][7:0] pl;
  frame_t held;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Error monitor: every strobe must match the next expected code.
  always @(negedge clk) begin
    if (rst_n && bus.o_err_strobe) begin
      if (exp_err_q.size() == 0) chk_eq("err_unexpected", 32'(bus.o_err_code), 32'(ERR_NONE));
      else chk_eq("err_code_q", 32'(bus.o_err_code), 32'(exp_err_q.pop_front()));
    end
    if (bus.o_frame_valid && !fv_d) frames_seen++;
    fv_d = bus.o_frame_valid;
  end

  task automatic drive(input logic [7:0] b);
    bus.i_rx_byte  = b;
    bus.i_rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Length, payload, checksum and EOF; queues the expected frame.
  task automatic send_body(input logic [7:0] len, input logic [MAX_LEN-1:0][7:0] d);
    frame_t f;
    logic [7:0] c;
    c = len;
    drive(len);
    for (int i = 0; i < int'(len); i++) begin
      c ^= d[i];
      drive(d[i]);
    end
    drive(c);
    f.len = len;
    f.data = d;
    exp_frame_q.push_back(f);
    frames_pushed++;
    drive(DEF_EOF_BYTE);
  endtask

  task automatic send_good(input logic [7:0] len, input logic [MAX_LEN-1:0][7:0] d);
    drive(DEF_SOF_BYTE);
    send_body(len, d);
  endtask

  // Called right after EOF: checks latency then compares the held buffer.
  task automatic check_held(input string tag);
    frame_t f;
    chk_eq({tag, "_fv"}, 32'(bus.o_frame_valid), 32'd1);
    if (exp_frame_q.size() == 0) begin
      chk_eq({tag, "_noexp"}, 32'(bus.o_frame_len), 32'd0);
    end else begin
      f = exp_frame_q.pop_front();
      chk_eq({tag, "_len"}, 32'(bus.o_frame_len), 32'(f.len));
      for (int i = 0; i < int'(f.len); i++) begin
        bus.i_rd_addr = 4'(i);
        #1;
        chk_eq($sformatf("%s_rd%0d", tag, i), 32'(bus.o_rd_data), 32'(f.data[i]));
      end
    end
  endtask

  task automatic ack();
    bus.i_frame_ack = 1'b1;
    @(posedge clk); #1;
    bus.i_frame_ack = 1'b0;
    chk_eq("ack_fv", 32'(bus.o_frame_valid), 32'd0);
    chk_eq("ack_busy", 32'(bus.o_busy), 32'd0);
  endtask

  initial begin
    bus.i_rx_byte = 8'h00;
    bus.i_rx_valid = 1'b0;
    bus.i_frame_ack = 1'b0;
    bus.i_rd_addr = '0;
    pl = '0;
    #12;
    chk_eq("rst_fv", 32'(bus.o_frame_valid), 32'd0);
    chk_eq("rst_busy", 32'(bus.o_busy), 32'd0);
    chk_eq("rst_strobe", 32'(bus.o_err_strobe), 32'd0);
    chk_eq("rst_code", 32'(bus.o_err_code), 32'd0);
    chk_eq("rst_drop", 32'(bus.o_drop_count), 32'd0);
    chk_eq("rst_len", 32'(bus.o_frame_len), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Good frame, checksum 03^11^22^33 = 03
    pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
    drive(8'h23); drive(8'h03); drive(8'h11); drive(8'h22); drive(8'h33); drive(8'h03);
    chk_eq("good_pre_eof_fv", 32'(bus.o_frame_valid), 32'd0);
    chk_eq("good_busy", 32'(bus.o_busy), 32'd1);
    exp_frame_q.push_back({8'h03, pl});
    frames_pushed++;
    drive(8'h0A);
    check_held("good");
    ack();

    // Bad checksum: 02^AA^55 = FD, not 00
    drive(8'h23); drive(8'h02); drive(8'hAA); drive(8'h55);
    exp_err_q.push_back(ERR_CHECKSUM);
    drive(8'h00);
    chk_eq("cks_strobe", 32'(bus.o_err_strobe), 32'd1);
    chk_eq("cks_code", 32'(bus.o_err_code), 32'(ERR_CHECKSUM));
    chk_eq("cks_busy", 32'(bus.o_busy), 32'd0);
    drive(8'h0A);
    chk_eq("cks_trail_fv", 32'(bus.o_frame_valid), 32'd0);
    chk_eq("cks_trail_busy", 32'(bus.o_busy), 32'd0);

    // Bad lengths: 0 and MAX_LEN+1
    drive(8'h23);
    exp_err_q.push_back(ERR_BAD_LEN);
    drive(8'h00);
    chk_eq("len0_code", 32'(bus.o_err_code), 32'(ERR_BAD_LEN));
    chk_eq("len0_busy", 32'(bus.o_busy), 32'd0);
    drive(8'h23);
    exp_err_q.push_back(ERR_BAD_LEN);
    drive(8'h11);
    chk_eq("len17_strobe", 32'(bus.o_err_strobe), 32'd1);
    chk_eq("len17_busy", 32'(bus.o_busy), 32'd0);
    pl = '0; pl[0] = 8'h7E;
    send_good(8'h01, pl);
    check_held("len1");
    ack();

    // Timeout with silence after the last byte
    drive(8'h23); drive(8'h02); drive(8'h10);
    idle(TO_CLKS);
    chk_eq("to_before_strobe", 32'(bus.o_err_strobe), 32'd0);
    chk_eq("to_before_busy", 32'(bus.o_busy), 32'd1);
    exp_err_q.push_back(ERR_TIMEOUT);
    idle(1);
    chk_eq("to_strobe", 32'(bus.o_err_strobe), 32'd1);
    chk_eq("to_code", 32'(bus.o_err_code), 32'(ERR_TIMEOUT));
    chk_eq("to_busy", 32'(bus.o_busy), 32'd0);

    // Byte on the terminal cycle wins; frame completes (02^10^20 = 32)
    drive(8'h23); drive(8'h02); drive(8'h10);
    idle(TO_CLKS);
    drive(8'h20);
    chk_eq("to_byte_strobe", 32'(bus.o_err_strobe), 32'd0);
    chk_eq("to_byte_busy", 32'(bus.o_busy), 32'd1);
    pl = '0; pl[0] = 8'h10; pl[1] = 8'h20;
    held = {8'h02, pl};
    exp_frame_q.push_back(held);
    frames_pushed++;
    drive(8'h32);
    drive(8'h0A);
    check_held("to_frame");

    // Overrun while holding unacked
    for (int i = 0; i < 300; i++) begin
      exp_err_q.push_back(ERR_OVERRUN);
      drive(8'($urandom_range(0, 255)));
    end
    chk_eq("ovr_drop", 32'(bus.o_drop_count), 32'd255);
    chk_eq("ovr_code", 32'(bus.o_err_code), 32'(ERR_OVERRUN));
    exp_frame_q.push_back(held);
    check_held("ovr_buf");

    // Ack coincident with SOF: straight to LEN, no extra drop
    bus.i_frame_ack = 1'b1;
    drive(8'h23);
    bus.i_frame_ack = 1'b0;
    chk_eq("ackb_fv", 32'(bus.o_frame_valid), 32'd0);
    chk_eq("ackb_busy", 32'(bus.o_busy), 32'd1);
    chk_eq("ackb_drop", 32'(bus.o_drop_count), 32'd255);
    chk_eq("ackb_strobe", 32'(bus.o_err_strobe), 32'd0);
    pl = '0; pl[0] = 8'h55; pl[1] = 8'h54;
    send_body(8'h02, pl);
    check_held("ackb_frame");
    ack();

    // Asynchronous reset in the middle of a payload
    drive(8'h23); drive(8'h04); drive(8'h01); drive(8'h02);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("mid_rst_busy", 32'(bus.o_busy), 32'd0);
    chk_eq("mid_rst_fv", 32'(bus.o_frame_valid), 32'd0);
    chk_eq("mid_rst_drop", 32'(bus.o_drop_count), 32'd0);
    chk_eq("mid_rst_code", 32'(bus.o_err_code), 32'd0);
    chk_eq("mid_rst_len", 32'(bus.o_frame_len), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    pl = '0; pl[0] = 8'hA5; pl[1] = 8'h5A;
    send_good(8'h02, pl);
    check_held("post_rst");
    ack();

    idle(3);
    chk_eq("err_q_empty", 32'(exp_err_q.size()), 32'd0);
    chk_eq("frames_seen", 32'(frames_seen), 32'(frames_pushed));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
